// File: rtl/shift_reg_pkg.sv
// Shared types for the shift_reg_n universal shift register: the operation
// encoding, the per-cell next-value select, and the occupancy counter width.
package shift_reg_pkg;

  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    SHL   = 3'd1,
    SHR   = 3'd2,
    LOAD  = 3'd3,
    ROTL  = 3'd4,
    ROTR  = 3'd5,
    CLEAR = 3'd6,
    RSVD  = 3'd7
  } shift_mode_e;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_LO   = 2'd1,
    SEL_HI   = 2'd2,
    SEL_PAR  = 2'd3
  } cell_sel_e;

  // The count must hold 0..depth inclusive, hence depth+1 codes.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shift_reg_cell.sv
// One stage of shift_reg_n: a WIDTH-bit data register and its valid bit,
// loaded from the lower neighbour, upper neighbour or parallel input.
module shift_reg_cell
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  cell_sel_e        sel,
  input  logic [WIDTH-1:0] lo_data,
  input  logic             lo_vld,
  input  logic [WIDTH-1:0] hi_data,
  input  logic             hi_vld,
  input  logic [WIDTH-1:0] par_data,
  output logic [WIDTH-1:0] data,
  output logic             vld
);

  // NOTE: reset is tested inside the clocked block only, so it is synchronous;
  // state updates use <= so every cell samples its neighbour's old value.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      data <= RST_VAL;
      vld  <= 1'b0;
    end else begin
      case (sel)
        SEL_LO: begin
          data <= lo_data;
          vld  <= lo_vld;
        end
        SEL_HI: begin
          data <= hi_data;
          vld  <= hi_vld;
        end
        SEL_PAR: begin
          data <= par_data;
          vld  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/shift_reg_n.sv
// Universal shift register / delay line: DEPTH valid-tagged stages with
// shift, rotate, parallel load, clear and a registered occupancy count.
module shift_reg_n
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en_i,
  input  logic [2:0]                    mode_i,
  input  logic [WIDTH-1:0]              ser_i,
  input  logic                          ser_vld_i,
  input  logic [WIDTH*DEPTH-1:0]        par_i,
  output logic [WIDTH*DEPTH-1:0]        par_o,
  output logic [WIDTH-1:0]              head_o,
  output logic                          head_vld_o,
  output logic [WIDTH-1:0]              tail_o,
  output logic                          tail_vld_o,
  output logic [cnt_width(DEPTH)-1:0]   cnt_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int CW = cnt_width(DEPTH);

  shift_mode_e      mode;
  cell_sel_e        sel;
  logic             clr;
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] lo_end_data, hi_end_data;
  logic             lo_end_vld, hi_end_vld;
  logic [CW-1:0]    cnt_q;

  assign mode = shift_mode_e'(mode_i);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sel = SEL_HOLD;
    clr = 1'b0;
    if (en_i) begin
      case (mode)
        SHL, ROTL: sel = SEL_LO;
        SHR, ROTR: sel = SEL_HI;
        LOAD:      sel = SEL_PAR;
        CLEAR:     clr = 1'b1;
        default:   sel = SEL_HOLD;
      endcase
    end
  end

  // End stages take serial input on shifts, the opposite end on rotates.
  always_comb begin
    lo_end_data = ser_i;
    lo_end_vld  = ser_vld_i;
    hi_end_data = ser_i;
    hi_end_vld  = ser_vld_i;
    if (mode == ROTL) begin
      lo_end_data = data[DEPTH-1];
      lo_end_vld  = vld[DEPTH-1];
    end
    if (mode == ROTR) begin
      hi_end_data = data[0];
      hi_end_vld  = vld[0];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] lo_d, hi_d;
    logic             lo_v, hi_v;

    if (k == 0) begin : g_lo_end
      assign lo_d = lo_end_data;
      assign lo_v = lo_end_vld;
    end else begin : g_lo_mid
      assign lo_d = data[k-1];
      assign lo_v = vld[k-1];
    end

    if (k == DEPTH - 1) begin : g_hi_end
      assign hi_d = hi_end_data;
      assign hi_v = hi_end_vld;
    end else begin : g_hi_mid
      assign hi_d = data[k+1];
      assign hi_v = vld[k+1];
    end

    shift_reg_cell #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .sel      (sel),
      .lo_data  (lo_d),
      .lo_vld   (lo_v),
      .hi_data  (hi_d),
      .hi_vld   (hi_v),
      .par_data (par_i[k*WIDTH +: WIDTH]),
      .data     (data[k]),
      .vld      (vld[k])
    );

    assign par_o[k*WIDTH +: WIDTH] = data[k];
  end

  // Shifts add the incoming tag and drop the tag falling off the far end;
  // the modular sum stays correct even when DEPTH+1 is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en_i) begin
      case (mode)
        SHL:     cnt_q <= cnt_q + CW'(ser_vld_i) - CW'(vld[DEPTH-1]);
        SHR:     cnt_q <= cnt_q + CW'(ser_vld_i) - CW'(vld[0]);
        LOAD:    cnt_q <= CW'(DEPTH);
        default: ;
      endcase
    end
  end

  assign head_o     = data[DEPTH-1];
  assign head_vld_o = vld[DEPTH-1];
  assign tail_o     = data[0];
  assign tail_vld_o = vld[0];
  assign cnt_o      = cnt_q;
  assign full_o     = (cnt_q == CW'(DEPTH));
  assign empty_o    = (cnt_q == '0);

endmodule

// File: tb/tb_shift_reg_n.sv
// Directed self-checking bench for shift_reg_n at WIDTH=8, DEPTH=4, RST_VAL=0.
module tb_shift_reg_n;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   en_i;
  logic [2:0]             mode_i;
  logic [WIDTH-1:0]       ser_i;
  logic                   ser_vld_i;
  logic [WIDTH*DEPTH-1:0] par_i;
  logic [WIDTH*DEPTH-1:0] par_o;
  logic [WIDTH-1:0]       head_o, tail_o;
  logic                   head_vld_o, tail_vld_o;
  logic [2:0]             cnt_o;
  logic                   full_o, empty_o;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] M_HOLD = 3'd0, M_SHL = 3'd1, M_SHR = 3'd2, M_LOAD = 3'd3,
                         M_ROTL = 3'd4, M_ROTR = 3'd5, M_CLEAR = 3'd6, M_RSVD = 3'd7;

  shift_reg_n #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en_i),
    .mode_i     (mode_i),
    .ser_i      (ser_i),
    .ser_vld_i  (ser_vld_i),
    .par_i      (par_i),
    .par_o      (par_o),
    .head_o     (head_o),
    .head_vld_o (head_vld_o),
    .tail_o     (tail_o),
    .tail_vld_o (tail_vld_o),
    .cnt_o      (cnt_o),
    .full_o     (full_o),
    .empty_o    (empty_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle 1 ns so outputs are sampled away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] m, input logic [7:0] s, input logic sv);
    mode_i    = m;
    ser_i     = s;
    ser_vld_i = sv;
  endtask

  initial begin
    rst = 1'b1; en_i = 1'b0; par_i = '0;
    drive(M_HOLD, 8'h00, 1'b0);
    step();
    check("rst_par", par_o, 32'h0);
    check("rst_cnt", 32'(cnt_o), 32'd0);
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_full", 32'(full_o), 32'd0);

    // Reset beats an enabled LOAD.
    rst = 1'b0; en_i = 1'b1; par_i = 32'hA4A3A2A1;
    drive(M_LOAD, 8'h00, 1'b0);
    step();
    check("preload_par", par_o, 32'hA4A3A2A1);
    check("preload_cnt", 32'(cnt_o), 32'd4);
    rst = 1'b1;
    step();
    check("rst_over_load_par", par_o, 32'h0);
    check("rst_over_load_cnt", 32'(cnt_o), 32'd0);
    check("rst_over_load_empty", 32'(empty_o), 32'd1);

    // A reset pulse entirely between edges must be ignored.
    rst = 1'b0;
    step();
    en_i = 1'b0;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    step();
    check("glitch_par", par_o, 32'hA4A3A2A1);
    check("glitch_cnt", 32'(cnt_o), 32'd4);

    // CLEAR then SHL fill.
    en_i = 1'b1;
    drive(M_CLEAR, 8'h00, 1'b0);
    step();
    check("clear_cnt", 32'(cnt_o), 32'd0);
    check("clear_par", par_o, 32'h0);
    drive(M_SHL, 8'h11, 1'b1);
    step();
    check("shl1_tail", 32'(tail_o), 32'h11);
    check("shl1_tail_vld", 32'(tail_vld_o), 32'd1);
    check("shl1_head_vld", 32'(head_vld_o), 32'd0);
    check("shl1_cnt", 32'(cnt_o), 32'd1);
    drive(M_SHL, 8'h22, 1'b1);
    step();
    check("shl2_cnt", 32'(cnt_o), 32'd2);
    drive(M_SHL, 8'h33, 1'b1);
    step();
    check("shl3_cnt", 32'(cnt_o), 32'd3);
    drive(M_SHL, 8'h44, 1'b1);
    step();
    check("shl4_head", 32'(head_o), 32'h11);
    check("shl4_tail", 32'(tail_o), 32'h44);
    check("shl4_par", par_o, 32'h11223344);
    check("shl4_cnt", 32'(cnt_o), 32'd4);
    check("shl4_full", 32'(full_o), 32'd1);
    drive(M_SHL, 8'h55, 1'b1);
    step();
    check("shl5_head", 32'(head_o), 32'h22);
    check("shl5_par", par_o, 32'h22334455);
    check("shl5_cnt", 32'(cnt_o), 32'd4);

    // LOAD and rotate round trip.
    par_i = 32'hA4A3A2A1;
    drive(M_LOAD, 8'h00, 1'b0);
    step();
    check("load_cnt", 32'(cnt_o), 32'd4);
    check("load_tail", 32'(tail_o), 32'hA1);
    drive(M_ROTL, 8'h00, 1'b0);
    step();
    check("rotl_par", par_o, 32'hA3A2A1A4);
    check("rotl_cnt", 32'(cnt_o), 32'd4);
    drive(M_ROTR, 8'h00, 1'b0);
    step();
    check("rotr_par", par_o, 32'hA4A3A2A1);

    // Enable gating and reserved encoding.
    en_i = 1'b0;
    drive(M_SHL, 8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("en0_par", par_o, 32'hA4A3A2A1);
      check("en0_cnt", 32'(cnt_o), 32'd4);
    end
    en_i = 1'b1;
    drive(M_RSVD, 8'hFF, 1'b1);
    step();
    check("rsvd_par", par_o, 32'hA4A3A2A1);
    check("rsvd_cnt", 32'(cnt_o), 32'd4);
    drive(M_HOLD, 8'hFF, 1'b1);
    step();
    check("hold_par", par_o, 32'hA4A3A2A1);

    // Bubble drain via SHR.
    drive(M_SHR, 8'h00, 1'b0);
    step();
    check("drain1_cnt", 32'(cnt_o), 32'd3);
    check("drain1_par", par_o, 32'h00A4A3A2);
    check("drain1_head_vld", 32'(head_vld_o), 32'd0);
    step();
    check("drain2_cnt", 32'(cnt_o), 32'd2);
    step();
    check("drain3_cnt", 32'(cnt_o), 32'd1);
    step();
    check("drain4_cnt", 32'(cnt_o), 32'd0);
    check("drain4_empty", 32'(empty_o), 32'd1);
    check("drain4_par", par_o, 32'h0);
    step();
    check("drain5_cnt", 32'(cnt_o), 32'd0);

    // SHR latency: a word enters at head and reaches tail after DEPTH edges.
    drive(M_SHR, 8'h5A, 1'b1);
    step();
    check("shr_in_head", 32'(head_o), 32'h5A);
    check("shr_in_cnt", 32'(cnt_o), 32'd1);
    drive(M_SHR, 8'h00, 1'b0);
    step();
    step();
    step();
    check("shr_lat_tail", 32'(tail_o), 32'h5A);
    check("shr_lat_tail_vld", 32'(tail_vld_o), 32'd1);
    check("shr_lat_cnt", 32'(cnt_o), 32'd1);

    // Reset in the middle of a shift stream, then resume.
    drive(M_CLEAR, 8'h00, 1'b0);
    step();
    drive(M_SHL, 8'h01, 1'b1);
    step();
    drive(M_SHL, 8'h02, 1'b1);
    step();
    check("pre_rst_par", par_o, 32'h00000102);
    rst = 1'b1;
    drive(M_SHL, 8'h03, 1'b1);
    step();
    check("mid_rst_par", par_o, 32'h0);
    check("mid_rst_cnt", 32'(cnt_o), 32'd0);
    rst = 1'b0;
    drive(M_SHL, 8'h04, 1'b1);
    step();
    check("resume_par", par_o, 32'h00000004);
    check("resume_cnt", 32'(cnt_o), 32'd1);
    drive(M_SHL, 8'h05, 1'b1);
    step();
    drive(M_SHL, 8'h06, 1'b1);
    step();
    check("pre_clear_cnt", 32'(cnt_o), 32'd3);
    check("pre_clear_par", par_o, 32'h00040506);
    drive(M_CLEAR, 8'hEE, 1'b1);
    step();
    check("clear3_cnt", 32'(cnt_o), 32'd0);
    check("clear3_par", par_o, 32'h0);
    check("clear3_empty", 32'(empty_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_reg_n.md
Name: shift_reg_n

Overview:
- Parametrised universal shift register / delay line: DEPTH stages, each WIDTH bits, with a per-stage valid bit.
- Successor to the single-bit D flip-flop: adds enable, parallel load, bidirectional shift, rotate, synchronous clear and occupancy tracking.
- Used as a configurable pipeline delay, serial/parallel converter, or small valid-tagged buffer between datapath blocks.

Parameters:
- WIDTH, 8, bits per stage (>=1)
- DEPTH, 4, number of stages (>=2)
- RST_VAL, 0, data value loaded into every stage on reset or CLEAR (WIDTH bits)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- en_i  input  1  operation enable; 0 = hold regardless of mode_i
- mode_i  input  3  operation select (see Behaviour)
- ser_i  input  WIDTH  serial data in
- ser_vld_i  input  1  valid tag for ser_i
- par_i  input  WIDTH*DEPTH  parallel load data; stage k = par_i[k*WIDTH +: WIDTH]
- par_o  output  WIDTH*DEPTH  all stage contents, same packing as par_i
- head_o  output  WIDTH  stage DEPTH-1 data
- head_vld_o  output  1  valid bit of stage DEPTH-1
- tail_o  output  WIDTH  stage 0 data
- tail_vld_o  output  1  valid bit of stage 0
- cnt_o  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH
- full_o  output  1  cnt_o == DEPTH
- empty_o  output  1  cnt_o == 0

Behaviour:
- Reset is synchronous and active-high: it acts only at a rising clk edge while rst=1; rst toggling between edges has no effect.
- Reset state: every stage = RST_VAL, every valid bit = 0, cnt_o = 0, empty_o = 1, full_o = 0.
- Priority at each edge: rst > en_i=0 (hold) > mode_i.
- Modes (encodings fixed):
  - 0 HOLD: no change.
  - 1 SHL: stage[0] <= ser_i, vld[0] <= ser_vld_i; stage[k] <= stage[k-1] and vld[k] <= vld[k-1] for k = 1..DEPTH-1. The old stage[DEPTH-1] is discarded.
  - 2 SHR: stage[DEPTH-1] <= ser_i, vld[DEPTH-1] <= ser_vld_i; stage[k] <= stage[k+1] and vld[k] <= vld[k+1]. The old stage[0] is discarded.
  - 3 LOAD: stage[k] <= par_i slice k; all vld <= 1.
  - 4 ROTL: stage[0] <= stage[DEPTH-1], stage[k] <= stage[k-1]; valid bits rotate with their data.
  - 5 ROTR: mirror of ROTL.
  - 6 CLEAR: identical to reset state.
  - 7 reserved: treated as HOLD.
- Outputs are driven directly from state registers, with no combinational path from inputs.
- Latency: an SHL word reaches head_o after DEPTH enabled SHL edges; an SHR word reaches tail_o after DEPTH enabled SHR edges.
- cnt_o always equals popcount(vld) after each edge. It may be held as a registered counter; if so, it must update by exactly -1, 0 or +1 on shifts, be set to DEPTH on LOAD, be 0 on CLEAR/reset, and be unchanged on rotates.
- Shifting with ser_vld_i=0 inserts a bubble: cnt_o drops when a valid word falls off the end.
- SHL with full_o=1 and ser_vld_i=1 is legal; the head word is overwritten and cnt_o stays DEPTH.
- Shifting while empty_o=1 with ser_vld_i=0 leaves cnt_o = 0.

Decomposition:
- Package shift_reg_pkg holds:
  - mode enum shift_mode_e (HOLD, SHL, SHR, LOAD, ROTL, ROTR, CLEAR, RSVD) as 3-bit logic;
  - a helper function for the cnt_o width.
- One natural sub-module, shift_reg_cell: a single stage plus its valid bit, with a 4-way next-value mux (hold / left neighbour / right neighbour / parallel).
- Top level handles the end-stage wiring (serial input vs. rotate feedback), the counter and the flag outputs.

Test Plan (WIDTH=8, DEPTH=4, RST_VAL=0):
1. Reset: preload via LOAD 0xA4A3A2A1, then rst=1 with en_i=1, mode=LOAD for one edge -> par_o=0x00000000, cnt_o=0, empty_o=1; a rst pulse that starts and ends between two edges -> no change.
2. SHL fill: shift in 0x11, 0x22, 0x33, 0x44 with vld=1 -> after the 4th edge head_o=0x11, tail_o=0x44, cnt_o=4, full_o=1; a 5th SHL of 0x55 -> head_o=0x22, cnt_o=4.
3. LOAD then rotate: LOAD par_i=0xA4A3A2A1 -> cnt_o=4, tail_o=0xA1; ROTL once -> par_o=0xA3A2A1A4; ROTR once -> par_o back to 0xA4A3A2A1.
4. Enable gating: en_i=0 with mode=SHL and ser_i=0xFF for 3 edges -> par_o and cnt_o unchanged; mode=7 with en_i=1 -> unchanged.
5. Bubble drain: from full, SHR with ser_vld_i=0 four times -> cnt_o goes 3, 2, 1, 0; empty_o=1 after the 4th edge; a 5th shift -> cnt_o stays 0.
6. Mid-operation reset and CLEAR: rst=1 during a stream of SHL edges -> next edge gives reset state, and shifting resumes from the empty state after rst=0; CLEAR mode at cnt_o=3 -> next edge cnt_o=0, par_o=0.
